// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- elastic pipeline stage.
//
// A DEPTH-entry circular buffer between two pipeline stages. It replaces a
// plain always-advancing register. Stalls on either side propagate through
// the ready signals, and a flush discards every held entry on a redirect.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on the same side. The producer holds valid/data stable until that
// edge. ready never depends combinationally on the peer's valid. in_ready
// comes only from the registered count, and out_valid likewise.
//
// Parameters
//   WIDTH      payload bits per entry (>= 1)
//   DEPTH      entry count, power of two, 2..16
//   RESET_VAL  value shown on out_data while out_valid = 0
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   upstream offers in_data
//   in_ready   buffer can accept this cycle
//   in_data    upstream payload
//   out_valid  head entry present
//   out_ready  downstream consumes the head this cycle
//   out_data   head payload (RESET_VAL when empty)
//   flush      synchronous discard of all entries
//   count      current occupancy, 0..DEPTH
//   stall_cycles  (only with PIPE_STAGE_BUF_STALL_CNT_EN) saturating count
//                 of cycles with out_valid & ~out_ready
//
// Build option: define PIPE_STAGE_BUF_STALL_CNT_EN to add stall_cycles.

module pipe_stage_buf #(
    parameter int unsigned           WIDTH     = 32,
    parameter int unsigned           DEPTH     = 2,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
`ifdef PIPE_STAGE_BUF_STALL_CNT_EN
    output logic [31:0]                  stall_cycles,
`endif
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Both flags come from the registered count only, so there is no
    // path from out_ready to in_ready.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : RESET_VAL;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Pointers and occupancy. Flush wins over any simultaneous push/pop.
    // The upstream handshake still completes during a flush, but the
    // pushed word is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_data;
    end

`ifdef PIPE_STAGE_BUF_STALL_CNT_EN
    // Counts back-pressure cycles. Flush does not clear it, only reset does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline stage: a DEPTH-entry circular buffer with valid/ready handshakes on both sides, synchronous flush, and an occupancy count. It is the stall- and flush-capable replacement for the fixed, always-advancing inter-stage registers between fetch/decode/execute/memory/writeback. Upstream and downstream stalls propagate via ready instead of freezing the whole core.

## Interface
- WIDTH, 32, payload bits per entry (≥1)
- DEPTH, 2, entries; power of two, 2..16 (DEPTH=2 gives full throughput with registered ready)
- RESET_VAL, '0, value driven on out_data whenever out_valid=0
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  buffer can accept this cycle
- in_data  input  WIDTH  payload
- out_valid  output  1  head entry present
- out_ready  input  1  downstream consumes head this cycle
- out_data  output  WIDTH  head payload
- flush  input  1  discard all entries (branch/jump redirect)
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the same rising edge.
- State: wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count, storage array.
- in_ready = (count != DEPTH), derived only from registered count. No combinational path from out_ready to in_ready.
- out_valid = (count != 0); out_data = storage[rd_ptr] when out_valid, else RESET_VAL.
- Push: storage[wr_ptr] ← in_data, wr_ptr+1. Pop: rd_ptr+1. count += push − pop.
- Simultaneous push and pop at 0<count<DEPTH: count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0, so in_valid is ignored even if pop occurs the same cycle; in_ready returns the cycle after the pop.
- Empty: pop impossible (out_valid=0); out_ready ignored.
- flush: next edge sets count=0 and wr_ptr=rd_ptr=0. Takes priority over a simultaneous push and pop; the pushed data is dropped, but the upstream handshake still completes (in_ready was 1).
- Upstream must hold in_valid/in_data stable until accepted; violation is not checked.
- Reset (async assert, any time): count=0, pointers=0, storage contents don't-care. Outputs immediately: out_valid=0, out_data=RESET_VAL, in_ready=1, count=0. Operation in progress is abandoned.

## Timing
- Latency: data pushed at edge N appears on out_data/out_valid after edge N (usable in cycle N+1); minimum 1 cycle.
- Throughput: one transfer per cycle sustained when out_ready=1 continuously.
- Fill: with out_ready=0, exactly DEPTH consecutive pushes are accepted; in_ready falls after the DEPTH-th.
- flush effect visible the cycle after assertion: out_valid=0, count=0, in_ready=1.
- All outputs are functions of registers only (out_data through the storage read mux), so there are no input-to-output combinational paths.

## Configuration
- PIPE_STAGE_BUF_STALL_CNT_EN defined: adds output stall_cycles [31:0]. It increments on each cycle with out_valid & ~out_ready, saturates at 32'hFFFF_FFFF, is unaffected by flush, and resets to 0.
- Not defined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset release, idle: out_valid=0, out_data=RESET_VAL (e.g. 0), in_ready=1, count=0.
- DEPTH=4, out_ready=0, push 0x11,0x22,0x33,0x44,0x55: first four accepted, in_ready=0 after the 4th, count=4, 0x55 held. Then out_ready=1: outputs 0x11,0x22,0x33,0x44,0x55 in order, and wrap-around is exercised.
- Streaming 100 words with in_valid=out_ready=1: one word per cycle, count stays 1, output equals input delayed 1 cycle.
- count=3, flush asserted with in_valid=1 (0xAA) and out_ready=1: next cycle count=0, out_valid=0, and 0xAA never appears at the output.
- Async reset asserted mid-cycle with count=2: outputs clear immediately without a clock edge, and resume cleanly after release.
- With PIPE_STAGE_BUF_STALL_CNT_EN: out_valid=1 with out_ready=0 for 7 cycles gives stall_cycles=7. A flush leaves it at 7.
